pipelined_rca: RTL and testbench
================================

Name: pipelined_rca

Overview:
Parametrised, pipelined successor to the combinational 32-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple-carry chunks of WIDTH/STAGES bits each. One chunk is evaluated per clock, with the carry registered between stages.
- Adds subtract mode, carry-in, a signed-overflow flag and a valid/ready handshake with backpressure.
- Sits in the datapath wherever the plain adder's critical path is too long for the target clock.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth and number of chunks; 1 <= STAGES <= WIDTH; CHUNK = WIDTH/STAGES.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
in_a  in  WIDTH  operand A, two's complement
in_b  in  WIDTH  operand B, two's complement
in_cin  in  1  carry-in; used in add mode only
in_sub  in  1  1 = A - B, 0 = A + B + cin
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_sum  out  WIDTH  result
out_cout  out  1  carry out of the MSB (in subtract mode, 1 = no borrow)
out_ovf  out  1  signed overflow

Behaviour:
- Reset:
  - rst_n low asynchronously clears every stage valid bit, carry register and operand/partial-sum register.
  - Outputs while in reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1.
  - A beat accepted in the same cycle rst_n deasserts is captured normally.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - During a stall every pipeline register holds, including out_*; out_sum, out_cout and out_ovf must not change while out_valid=1 and out_ready=0.
  - Bubbles are not collapsed: the whole pipe advances one stage per non-stalled cycle, valid or not.
- Operand preprocessing at acceptance:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin.
- Stage k (k = 0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of A and b_eff with the registered carry from stage k-1 (c0 for stage 0).
  - Writes the partial sum into its slice of the result register.
  - Registers carry-out for stage k+1.
  - Upper operand slices travel down a skew-delay pipeline alongside the beat; lower result slices travel with it.
- Final stage:
  - Computes c_msb_in, the carry into bit WIDTH-1.
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = c_msb_in XOR out_cout (signed overflow, valid in both add and subtract modes).
  - The result is not truncated or saturated; out_sum is the WIDTH-bit wrap-around value.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no stall. Each stall cycle adds one cycle.
- Throughput: one beat per cycle with out_ready held high; results emerge in acceptance order.
- STAGES=1 degenerates to a single registered adder with latency 1.
- in_valid=0 inserts a bubble; the stage valid bit is 0 and the data registers may update freely.
- Reset mid-operation: all in-flight beats are discarded, no spurious out_valid after release, and the first post-reset result is the first post-reset accepted beat.

Test Plan:
(WIDTH=32, STAGES=4 unless stated.)
- Negative overflow: A=0x80000001, B=0x80000001, add, cin=0 -> 4 cycles later out_sum=0x00000002, out_cout=1, out_ovf=1.
- Positive overflow: A=0x7FFFFFFF, B=0x7FFFFFFF, add -> out_sum=0xFFFFFFFE, cout=0, ovf=1.
- Inter-chunk carry: 0x0000FFFF+0x00000001 -> out_sum=0x00010000, cout=0, ovf=0.
- Back-to-back stream, out_ready=1, three consecutive beats:
  - 0x70FF9FFC+0xF2FD9FFC -> 0x63FD3FF8, cout=1, ovf=0
  - 0+0 with cin=1 -> 0x00000001
  - 0x508FBFFC+0x329DDF9C -> 0x832D9F98, ovf=1
  - Results appear on three consecutive cycles starting at cycle 4.
- Subtract:
  - 5-7 -> 0xFFFFFFFE, cout=0, ovf=0
  - 0x80000000-1 -> 0x7FFFFFFF, cout=1, ovf=1
- Backpressure and reset:
  - With a result at the output, hold out_ready=0 for 3 cycles -> out_* stable, in_ready=0, no beat lost or duplicated after release.
  - Then drop rst_n with 3 beats in flight -> out_valid=0 immediately; nothing is emitted until new beats are accepted.
  - Repeat the stream test with STAGES=1 and STAGES=8 -> same sums at latency 1 and 8.

Source files
------------

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/subtract: WIDTH bits split into STAGES chunks,
// one chunk per clock, carry registered between stages, valid/ready flow control.
module pipelined_rca #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // Registers after each stage; index STAGES-1 is the output stage.
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] sum_p [STAGES];
  logic             cy_p  [STAGES];
  logic             vld_p [STAGES];
  logic             ovf_p;

  logic [WIDTH-1:0] a_src   [STAGES];
  logic [WIDTH-1:0] b_src   [STAGES];
  logic [WIDTH-1:0] sum_src [STAGES];
  logic [WIDTH-1:0] sum_nxt [STAGES];
  logic             cy_src  [STAGES];
  logic             cy_nxt  [STAGES];
  logic             vld_src [STAGES];
  logic [CHUNK:0]   part;
  logic             ovf_nxt;
  logic             stall;

  assign stall    = vld_p[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    // Stage 0 sees the preprocessed operands; subtract is A + ~B + 1.
    a_src[0]   = in_a;
    b_src[0]   = in_sub ? ~in_b : in_b;
    cy_src[0]  = in_sub | in_cin;
    sum_src[0] = '0;
    vld_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]   = a_p[k-1];
      b_src[k]   = b_p[k-1];
      cy_src[k]  = cy_p[k-1];
      sum_src[k] = sum_p[k-1];
      vld_src[k] = vld_p[k-1];
    end
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
           + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, cy_src[k]};
      sum_nxt[k] = sum_src[k];
      sum_nxt[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      cy_nxt[k] = part[CHUNK];
    end
    // Carry into the MSB is recovered as a^b^sum at that bit.
    ovf_nxt = a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1]
            ^ sum_nxt[STAGES-1][WIDTH-1] ^ cy_nxt[STAGES-1];
  end

  // Whole pipe advances together, bubbles included; a stall freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        sum_p[k] <= '0;
        cy_p[k]  <= 1'b0;
        vld_p[k] <= 1'b0;
      end
      ovf_p <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= a_src[k];
        b_p[k]   <= b_src[k];
        sum_p[k] <= sum_nxt[k];
        cy_p[k]  <= cy_nxt[k];
        vld_p[k] <= vld_src[k];
      end
      ovf_p <= ovf_nxt;
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign out_sum   = sum_p[STAGES-1];
  assign out_cout  = cy_p[STAGES-1];
  assign out_ovf   = ovf_p;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: three instances (STAGES 1, 4, 8) share the input
// stream; an arithmetic reference model plus directed literal vectors.
module tb_pipelined_rca;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_cin, in_sub;
  logic [31:0] in_a, in_b;
  logic        ordy [3];
  logic        irdy [3];
  logic        ov   [3];
  logic        oc   [3];
  logic        oo   [3];
  logic [31:0] os   [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipelined_rca #(.WIDTH(32), .STAGES(g == 0 ? 1 : (g == 1 ? 4 : 8))) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(irdy[g]),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .out_sum(os[g]), .out_cout(oc[g]), .out_ovf(oo[g])
    );
  end

  function automatic int stg(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: {ovf, cout, sum} from signed/unsigned integer math.
  function automatic logic [33:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic ci, input logic sb);
    longint sa, sbv, r;
    logic [32:0] u;
    logic cout, ovf;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      u    = {1'b0, a - b};
      cout = (a >= b);
      r    = sa - sbv;
    end else begin
      u    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      cout = u[32];
      r    = sa + sbv + longint'(ci);
    end
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {ovf, cout, u[31:0]};
  endfunction

  // Model: per instance, in-flight results with the number of advancing
  // edges since acceptance; a result is visible once its age equals STAGES.
  logic [33:0] mq   [3][16];
  int          mage [3][16];
  int          mcnt [3] = '{0, 0, 0};

  always @(negedge clk) begin
    logic ev, er;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        mcnt[d] = 0;
        chk($sformatf("rst_valid_s%0d", stg(d)), ov[d], 0);
        chk($sformatf("rst_sum_s%0d", stg(d)), os[d], 0);
        chk($sformatf("rst_cout_s%0d", stg(d)), oc[d], 0);
        chk($sformatf("rst_ovf_s%0d", stg(d)), oo[d], 0);
        chk($sformatf("rst_inready_s%0d", stg(d)), irdy[d], 1);
      end else begin
        ev = (mcnt[d] > 0) && (mage[d][0] == stg(d));
        chk($sformatf("mdl_valid_s%0d", stg(d)), ov[d], ev);
        if (ev) begin
          chk($sformatf("mdl_sum_s%0d", stg(d)), os[d], mq[d][0][31:0]);
          chk($sformatf("mdl_cout_s%0d", stg(d)), oc[d], mq[d][0][32]);
          chk($sformatf("mdl_ovf_s%0d", stg(d)), oo[d], mq[d][0][33]);
        end
        er = !(ev && !ordy[d]);
        chk($sformatf("mdl_inready_s%0d", stg(d)), irdy[d], er);
        if (er) begin
          if (ev) begin
            for (int i = 0; i < mcnt[d] - 1; i++) begin
              mq[d][i]   = mq[d][i+1];
              mage[d][i] = mage[d][i+1];
            end
            mcnt[d]--;
          end
          for (int i = 0; i < mcnt[d]; i++) mage[d][i]++;
          if (in_valid && mcnt[d] < 16) begin
            mq[d][mcnt[d]]   = calc(in_a, in_b, in_cin, in_sub);
            mage[d][mcnt[d]] = 1;
            mcnt[d]++;
          end
        end
      end
    end
  end

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  // One beat, then literal check of latency and result on the STAGES=4 instance.
  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sb, input logic [31:0] es, input logic ec,
                        input logic eo, input string nm);
    int n;
    in_a = a; in_b = b; in_cin = ci; in_sub = sb; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[1] && n < 20);
    chk({nm, "_latency"}, n, 4);
    chk({nm, "_sum"}, os[1], es);
    chk({nm, "_cout"}, oc[1], ec);
    chk({nm, "_ovf"}, oo[1], eo);
    @(posedge clk); #1;
  endtask

  task automatic stream();
    logic [31:0] sa [3];
    logic [31:0] sb [3];
    logic [31:0] se [3];
    logic        sci [3];
    logic        eco [3];
    logic        eov [3];
    sa  = '{32'h70FF9FFC, 32'h00000000, 32'h508FBFFC};
    sb  = '{32'hF2FD9FFC, 32'h00000000, 32'h329DDF9C};
    sci = '{1'b0, 1'b1, 1'b0};
    se  = '{32'h63FD3FF8, 32'h00000001, 32'h832D9F98};
    eco = '{1'b1, 1'b0, 1'b0};
    eov = '{1'b0, 1'b0, 1'b1};
    in_a = sa[0]; in_b = sb[0]; in_cin = sci[0]; in_sub = 1'b0; in_valid = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n < 3) begin
        in_a = sa[n]; in_b = sb[n]; in_cin = sci[n];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (n >= stg(d) && n < stg(d) + 3) begin
          chk($sformatf("stream_valid_s%0d_c%0d", stg(d), n), ov[d], 1);
          chk($sformatf("stream_sum_s%0d_c%0d", stg(d), n), os[d], se[n-stg(d)]);
          chk($sformatf("stream_cout_s%0d_c%0d", stg(d), n), oc[d], eco[n-stg(d)]);
          chk($sformatf("stream_ovf_s%0d_c%0d", stg(d), n), oo[d], eov[n-stg(d)]);
        end else begin
          chk($sformatf("stream_valid_s%0d_c%0d", stg(d), n), ov[d], 0);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic backpressure();
    in_a = 32'h12345678; in_b = 32'h11111111; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 ordy[1] = 1'b0;
    @(posedge clk); #1;
    in_a = 32'hFFFFFFFF; in_b = 32'h00000002; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", ov[1], 1);
      chk("stall_sum", os[1], 32'h23456789);
      chk("stall_cout", oc[1], 0);
      chk("stall_ovf", oo[1], 0);
      chk("stall_inready", irdy[1], 0);
      @(posedge clk); #1;
    end
    ordy[1] = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      chk($sformatf("release_valid_c%0d", n), ov[1], (n == 4));
      if (n == 4) begin
        chk("release_sum", os[1], 32'h00000001);
        chk("release_cout", oc[1], 1);
        chk("release_ovf", oo[1], 0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    in_a = 32'h00000011; in_b = 32'h00000022; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_a = 32'h00000033;
    @(posedge clk); #1 in_a = 32'h00000044;
    @(posedge clk); #1 in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", ov[1], 0);
    chk("midrst_sum", os[1], 0);
    chk("midrst_inready", irdy[1], 1);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk($sformatf("postrst_idle_s%0d_c%0d", stg(d), n), ov[d], 0);
    end
    @(posedge clk); #1;
    single(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, "postrst");
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    ordy[0] = 1'b1; ordy[1] = 1'b1; ordy[2] = 1'b1;
    #12;
    chk("reset_valid", ov[1], 0);
    chk("reset_sum", os[1], 0);
    chk("reset_cout", oc[1], 0);
    chk("reset_ovf", oo[1], 0);
    chk("reset_inready", irdy[1], 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    single(32'h80000001, 32'h80000001, 1'b0, 1'b0, 32'h00000002, 1'b1, 1'b1, "negovf");
    single(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, "posovf");
    single(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, "chunkcarry");
    single(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub5m7");
    single(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "subovf");
    drain();
    stream();
    drain();
    backpressure();
    drain();
    reset_mid();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: summary not reached by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
